// File: rtl/buzz_pkg.sv
// Shared buzzer definitions: event codes, owner encoding, notes, event priority
// and the pattern ROM that maps (event, step) to a note or gap.
package buzz_pkg;

    typedef enum logic [2:0] {
        EVT_STOP  = 3'd0,
        EVT_OK    = 3'd1,
        EVT_ERROR = 3'd2,
        EVT_ALARM = 3'd3,
        EVT_OPEN  = 3'd4
    } evt_code_e;

    typedef enum logic [2:0] {S_IDLE, S_CLICK, S_NOTE, S_GAP, S_ALARM} state_e;

    typedef logic [2:0] note_t;
    typedef logic [1:0] src_t;

    localparam src_t  SRC_NONE   = 2'd0;
    localparam src_t  SRC_KEY    = 2'd1;
    localparam src_t  SRC_EVT    = 2'd2;
    localparam src_t  SRC_ALARM  = 2'd3;

    localparam note_t NOTE_OFF   = 3'd0;
    localparam note_t NOTE_CLICK = 3'd7;

    typedef struct packed {
        note_t note;
        logic  gap;
        logic  last;
    } step_t;

    function automatic logic evt_is_valid(input logic [2:0] code);
        return code <= EVT_OPEN;
    endfunction

    // Key click sits at priority 0, so any valid event outranks it.
    function automatic logic [2:0] evt_prio(input logic [2:0] code);
        case (code)
            EVT_ALARM: return 3'd4;
            EVT_ERROR: return 3'd3;
            EVT_OPEN:  return 3'd2;
            EVT_OK:    return 3'd1;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic step_t pattern_step(input logic [2:0] code, input logic [2:0] step);
        step_t s;
        s = '{note: NOTE_OFF, gap: 1'b0, last: 1'b1};
        case (code)
            EVT_OK: begin
                s.note = (step == 3'd0) ? 3'd1 : (step == 3'd1) ? 3'd3 : 3'd5;
                s.last = (step >= 3'd2);
            end
            EVT_OPEN: begin
                s.note = (step == 3'd0) ? 3'd5 : (step == 3'd1) ? 3'd3 : 3'd1;
                s.last = (step >= 3'd2);
            end
            EVT_ERROR: begin
                s.gap  = step[0];
                s.note = step[0] ? NOTE_OFF : 3'd1;
                s.last = (step >= 3'd4);
            end
            EVT_ALARM: begin
                s.note = step[0] ? 3'd7 : 3'd6;
                s.last = 1'b0;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/buzz_if.sv
// Request/status bundle between the keypad/main FSM and the buzzer arbiter.
interface buzz_if;
    import buzz_pkg::*;

    logic       key_req;
    logic       evt_req;
    logic [2:0] evt_code;
    note_t      note;
    logic       busy;
    src_t       src;
    logic       done;

    modport master (output key_req, evt_req, evt_code, input note, busy, src, done);
    modport slave  (input key_req, evt_req, evt_code, output note, busy, src, done);
endinterface

// File: rtl/buzz_step_timer.sv
// Loadable millisecond step timer: TICK_DIV prescaler feeding an ms down-counter,
// expire pulses for one cycle on the final clock of the loaded duration.
module buzz_step_timer #(
    parameter int TICK_DIV = 1000,
    parameter int MS_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [MS_W-1:0] load_ms,
    output logic            expire
);
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [MS_W-1:0]  ms_left;
    logic             tick;

    assign tick   = (pre == PRE_LAST);
    assign expire = tick && (ms_left == MS_W'(1));

    // ms_left parks at zero once a step ends; loading zero is a clean stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre     <= '0;
            ms_left <= '0;
        end else if (load) begin
            pre     <= '0;
            ms_left <= load_ms;
        end else if (ms_left != '0) begin
            if (tick) begin
                pre     <= '0;
                ms_left <= ms_left - MS_W'(1);
            end else begin
                pre     <= pre + PRE_W'(1);
            end
        end
    end
endmodule

// File: rtl/buzz_arbiter.sv
// Buzzer owner: arbitrates key clicks against main-FSM sound events and
// sequences note patterns. Define BUZZ_QUEUE_EN to keep one dropped event pending.
module buzz_arbiter
    import buzz_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CLICK_MS = 50,
    parameter int NOTE_MS  = 200,
    parameter int GAP_MS   = 100
) (
    input  logic  clk,
    input  logic  reset,
    buzz_if.slave bus
);
    localparam int MS_MAX = (NOTE_MS > CLICK_MS) ? ((NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS)
                                                 : ((CLICK_MS > GAP_MS) ? CLICK_MS : GAP_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    state_e          state_q, state_d;
    logic [2:0]      code_q, code_d, step_q, step_d, nxt_step, act_prio, start_code;
    note_t           note_q, note_d;
    src_t            src_q, src_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            tmr_load, expire, evt_ok, stop_evt, start_evt, start;
    logic [MS_W-1:0] tmr_ms;
    step_t           cur, rom;
    logic            unused_rom;

    assign evt_ok     = bus.evt_req && evt_is_valid(bus.evt_code);
    assign act_prio   = (state_q == S_IDLE || state_q == S_CLICK) ? 3'd0 : evt_prio(code_q);
    assign stop_evt   = evt_ok && (bus.evt_code == EVT_STOP);
    assign start_evt  = evt_ok && !stop_evt && (evt_prio(bus.evt_code) >= act_prio);
    assign nxt_step   = (state_q == S_ALARM) ? {2'b00, ~step_q[0]} : step_q + 3'd1;
    assign cur        = pattern_step(code_q, step_q);
    assign rom        = pattern_step(code_q, nxt_step);
    assign unused_rom = ^{cur.note, cur.gap, rom.last};

`ifdef BUZZ_QUEUE_EN
    logic       pend_vld_q, pend_take;
    logic [2:0] pend_code_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
        end else if (stop_evt) begin
            pend_vld_q  <= 1'b0;
        end else if (evt_ok && !start_evt && bus.evt_code != EVT_ALARM) begin
            pend_vld_q  <= 1'b1;
            pend_code_q <= bus.evt_code;
        end else if (pend_take) begin
            pend_vld_q  <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        step_d     = step_q;
        note_d     = note_q;
        busy_d     = busy_q;
        src_d      = src_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_ms     = '0;
        start      = 1'b0;
        start_code = bus.evt_code;
`ifdef BUZZ_QUEUE_EN
        pend_take  = 1'b0;
`endif
        if (stop_evt) begin
            state_d  = S_IDLE;
            note_d   = NOTE_OFF;
            busy_d   = 1'b0;
            src_d    = SRC_NONE;
            tmr_load = 1'b1;
        end else if (start_evt) begin
            start = 1'b1;
`ifdef BUZZ_QUEUE_EN
        end else if (pend_vld_q && state_q == S_IDLE) begin
            start      = 1'b1;
            start_code = pend_code_q;
            pend_take  = 1'b1;
`endif
        end else if (bus.key_req && (state_q == S_IDLE || state_q == S_CLICK)) begin
            state_d  = S_CLICK;
            note_d   = NOTE_CLICK;
            busy_d   = 1'b1;
            src_d    = SRC_KEY;
            tmr_load = 1'b1;
            tmr_ms   = MS_W'(CLICK_MS);
        end else if (expire) begin
            // On expiry either go silent/idle or load the following step.
            if (state_q == S_CLICK || ((state_q == S_NOTE || state_q == S_GAP) && cur.last)) begin
                state_d = S_IDLE;
                note_d  = NOTE_OFF;
                busy_d  = 1'b0;
                src_d   = SRC_NONE;
                done_d  = (state_q != S_CLICK);
            end else if (state_q != S_IDLE) begin
                step_d   = nxt_step;
                note_d   = rom.note;
                tmr_load = 1'b1;
                tmr_ms   = rom.gap ? MS_W'(GAP_MS) : MS_W'(NOTE_MS);
                if (state_q != S_ALARM)
                    state_d = rom.gap ? S_GAP : S_NOTE;
            end
        end

        if (start) begin
            code_d   = start_code;
            step_d   = '0;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_ms   = MS_W'(NOTE_MS);
            note_d   = pattern_step(start_code, 3'd0).note;
            state_d  = (start_code == EVT_ALARM) ? S_ALARM : S_NOTE;
            src_d    = (start_code == EVT_ALARM) ? SRC_ALARM : SRC_EVT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            step_q  <= '0;
            note_q  <= NOTE_OFF;
            busy_q  <= 1'b0;
            src_q   <= SRC_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            step_q  <= step_d;
            note_q  <= note_d;
            busy_q  <= busy_d;
            src_q   <= src_d;
            done_q  <= done_d;
        end
    end

    buzz_step_timer #(.TICK_DIV(TICK_DIV), .MS_W(MS_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_ms (tmr_ms),
        .expire  (expire)
    );

    assign bus.note = note_q;
    assign bus.busy = busy_q;
    assign bus.src  = src_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_buzz_arbiter.sv
// Scoreboard bench for buzz_arbiter: per-cycle expected outputs are queued with
// the stimulus and popped one per clock. Click 8, note 12, gap 4 cycles.
module tb_buzz_arbiter;
    import buzz_pkg::*;

    typedef struct packed {
        logic [2:0] note;
        logic       busy;
        logic [1:0] src;
        logic       done;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    buzz_if bus();

    buzz_arbiter #(.TICK_DIV(4), .CLICK_MS(2), .NOTE_MS(3), .GAP_MS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs();
        obs_t o;
        o.note = bus.note;
        o.busy = bus.busy;
        o.src  = bus.src;
        o.done = bus.done;
        return o;
    endfunction

    task automatic expect_n(input int n, input logic [2:0] nt, input logic b,
                            input logic [1:0] s, input logic d);
        obs_t x;
        x = '{note: nt, busy: b, src: s, done: d};
        repeat (n) exp_q.push_back(x);
    endtask

    // Advance to 1 time unit past the next rising edge and retire request pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.key_req = 1'b0;
        bus.evt_req = 1'b0;
    endtask

    task automatic send_evt(input logic [2:0] code);
        bus.evt_req  = 1'b1;
        bus.evt_code = code;
    endtask

    task automatic test_reset();
        obs_t o, e;
        bus.key_req = 1'b0; bus.evt_req = 1'b0; bus.evt_code = 3'd0;
        reset = 1'b1;
        #12;
        expect_n(2, 0, 0, 0, 0);
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_hold: got %b want %b", o, e); end
        #11 reset = 1'b0;
        tick();
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL reset_idle: got %b want %b", o, e); end
    endtask

    // Click of 8 cycles; a second key at c4 restarts it from full length.
    task automatic test_click();
        obs_t o, e;
        expect_n(4, 7, 1, 1, 0);
        expect_n(8, 7, 1, 1, 0);
        expect_n(3, 0, 0, 0, 0);
        for (int c = 0; c < 15; c++) begin
            if (c == 0 || c == 4) bus.key_req = 1'b1;
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL click c%0d: got %b want %b", c, o, e); end
        end
    endtask

    task automatic test_error();
        obs_t o, e;
        expect_n(12, 1, 1, 2, 0); expect_n(4, 0, 1, 2, 0);
        expect_n(12, 1, 1, 2, 0); expect_n(4, 0, 1, 2, 0);
        expect_n(12, 1, 1, 2, 0);
        expect_n(1, 0, 0, 0, 1);
        expect_n(3, 0, 0, 0, 0);
        for (int c = 0; c < 48; c++) begin
            if (c == 0) send_evt(EVT_ERROR);
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL error c%0d: got %b want %b", c, o, e); end
        end
    endtask

    // OK pre-empted by ALARM during its second note, then STOP.
    task automatic test_alarm();
        obs_t o, e;
        expect_n(12, 1, 1, 2, 0); expect_n(1, 3, 1, 2, 0);
        expect_n(12, 6, 1, 3, 0); expect_n(12, 7, 1, 3, 0);
        expect_n(4, 6, 1, 3, 0);
        expect_n(2, 0, 0, 0, 0);
        for (int c = 0; c < 43; c++) begin
            if (c == 0)  send_evt(EVT_OK);
            if (c == 13) send_evt(EVT_ALARM);
            if (c == 41) send_evt(EVT_STOP);
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL alarm c%0d: got %b want %b", c, o, e); end
        end
    endtask

    // Lower-priority OK and a key press during ERROR are dropped (or OK queued).
    task automatic test_drop();
        obs_t o, e;
        int   ncyc;
        expect_n(12, 1, 1, 2, 0); expect_n(4, 0, 1, 2, 0);
        expect_n(12, 1, 1, 2, 0); expect_n(4, 0, 1, 2, 0);
        expect_n(12, 1, 1, 2, 0);
        expect_n(1, 0, 0, 0, 1);
`ifdef BUZZ_QUEUE_EN
        expect_n(12, 1, 1, 2, 0); expect_n(12, 3, 1, 2, 0); expect_n(12, 5, 1, 2, 0);
        expect_n(1, 0, 0, 0, 1);
        expect_n(1, 0, 0, 0, 0);
        ncyc = 83;
`else
        expect_n(5, 0, 0, 0, 0);
        ncyc = 50;
`endif
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0)  send_evt(EVT_ERROR);
            if (c == 5)  send_evt(EVT_OK);
            if (c == 20) bus.key_req = 1'b1;
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL drop c%0d: got %b want %b", c, o, e); end
        end
    endtask

    // Key + OPEN together: OPEN wins. Then reserved codes are ignored, alone and with a key.
    task automatic test_collide();
        obs_t o, e;
        expect_n(12, 5, 1, 2, 0); expect_n(12, 3, 1, 2, 0); expect_n(12, 1, 1, 2, 0);
        expect_n(1, 0, 0, 0, 1);
        expect_n(2, 0, 0, 0, 0);
        expect_n(8, 7, 1, 1, 0);
        expect_n(1, 0, 0, 0, 0);
        for (int c = 0; c < 48; c++) begin
            if (c == 0) begin bus.key_req = 1'b1; send_evt(EVT_OPEN); end
            if (c == 37) send_evt(3'd6);
            if (c == 39) begin bus.key_req = 1'b1; send_evt(3'd5); end
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL collide c%0d: got %b want %b", c, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        expect_n(6, 1, 1, 2, 0);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) send_evt(EVT_ERROR);
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_pre c%0d: got %b want %b", c, o, e); end
        end
        expect_n(2, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rst_async: got %b want %b", o, e); end
        @(posedge clk);
        #1;
        e = exp_q.pop_front(); o = obs(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rst_held: got %b want %b", o, e); end
        #2 reset = 1'b0;
        expect_n(8, 7, 1, 1, 0);
        expect_n(2, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            if (c == 0) bus.key_req = 1'b1;
            tick();
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_click c%0d: got %b want %b", c, o, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_click();
        test_error();
        test_alarm();
        test_drop();
        test_collide();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/buzz_arbiter.md
Name: buzz_arbiter

Overview:
- Single owner of the door-lock buzzer: arbitrates between keypad click requests and main-FSM sound events.
- Sequences multi-note patterns and drives a note index to the downstream tone generator.
- Sits between the keypad/main FSM and the sound generator; neither requester drives the buzzer directly any more.

Parameters:
- TICK_DIV, 1000: clk cycles per 1 ms duration tick.
- CLICK_MS, 50: key click length in ms.
- NOTE_MS, 200: pattern note length in ms.
- GAP_MS, 100: silent gap length in ms.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- key_req  in  1  one-cycle pulse per accepted key press.
- evt_req  in  1  one-cycle pulse: main FSM sound event.
- evt_code  in  3  event code, sampled with evt_req: 0 STOP, 1 OK, 2 ERROR, 3 ALARM, 4 OPEN, 5–7 reserved.
- note  out  3  note index to tone generator; 0 = silent, 1–7 = pitch.
- busy  out  1  high whenever note sequencing is active, including gaps.
- src  out  2  current owner: 0 none, 1 key, 2 event, 3 alarm.
- done  out  1  one-cycle pulse when an OK/ERROR/OPEN pattern completes naturally.

Behaviour:
- Reset values: note=0, busy=0, src=0, done=0; FSM in IDLE; all counters cleared.
- Reset asserted mid-pattern aborts immediately to these values.
- FSM states: IDLE, CLICK, NOTE, GAP, ALARM.
- Patterns, as step lists (N = note for NOTE_MS, G = gap for GAP_MS):
  - OK: N1, N3, N5.
  - ERROR: N1, G, N1, G, N1.
  - OPEN: N5, N3, N1.
  - ALARM: N6, N7, repeating until STOP.
- Duration counter reloads at every step start. Each step lasts exactly ms × TICK_DIV cycles.
- Outputs are registered. note changes in the cycle after the request pulse, then once per step boundary.
- Priority: ALARM > ERROR > OPEN > OK > key click.
- evt_req with a valid code whose priority is ≥ the active one restarts at step 0 of the new pattern. Lower priority is dropped.
- STOP (code 0) from any state: next cycle IDLE, note=0, done not pulsed.
- Reserved codes are ignored entirely.
- key_req:
  - IDLE: enter CLICK, note=7, src=1, for CLICK_MS.
  - CLICK: the click restarts from full length.
  - NOTE/GAP/ALARM: dropped.
- key_req and evt_req in the same cycle: the event wins and the key is dropped.
- Last pattern step expires: done=1 for one cycle, together with IDLE, note=0, busy=0, src=0.
- CLICK expiry returns to IDLE without done.
- ALARM never self-terminates. Only STOP or reset ends it.
- Counters:
  - Width = clog2 of the maximum duration in cycles.
  - No wrap-around is permitted; the counter saturates at terminal, then reloads.

Optional Feature:
- BUZZ_QUEUE_EN defined:
  - One-deep pending slot holds the latest dropped lower-priority OK/ERROR/OPEN event.
  - The held event starts in the cycle after the active pattern's done. A newer dropped event overwrites the slot.
  - STOP and reset clear the slot.
  - Key clicks are never queued.
- BUZZ_QUEUE_EN not defined: dropped events are lost; no slot logic exists.

Decomposition:
- Shared package buzz_pkg holds:
  - event code constants;
  - src encoding;
  - note constants;
  - priority function;
  - pattern ROM function (code, step → note or gap, last-step flag).
- Sub-module buzz_step_timer: loadable ms-step down-counter with TICK_DIV prescaler and a single-cycle expire output. The arbiter FSM instantiates it once.

Test Plan:
Bench parameters: TICK_DIV=4, CLICK_MS=2, NOTE_MS=3, GAP_MS=1, so click = 8 cycles, note = 12 cycles, gap = 4 cycles.
- key_req at t0 → note=7, src=1 during t1..t8; note=0, busy=0 at t9; done stays 0.
- ERROR at t0 → note 1,0,1,0,1 for 12/4/12/4/12 cycles (t1..t44); done=1 only at t45, when note=0 and busy=0.
- OK running, ALARM at step 1 → next cycle note=6, src=3; 6/7 alternates every 12 cycles; STOP → note=0 next cycle, no done.
- ERROR running, OK request and key_req mid-pattern → both ignored; ERROR completes at its original t45.
  - With BUZZ_QUEUE_EN: OK starts at t46, giving notes 1,3,5.
- key_req and evt_req(OPEN) in the same cycle → note=5, src=2; no click.
- reset asserted mid-NOTE → all outputs zero asynchronously; after release, key_req behaves as from power-up.
